// File: rtl/dirty_writeback_buffer.sv
// Write-back buffer for evicted dirty cache lines. Lines drain to memory as
// 8-beat AW/W/B bursts in FIFO order and stay visible to read lookups until retired.
module dirty_writeback_buffer #(
  parameter int DEPTH      = 2,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [32*LINE_WORDS-1:0] push_data,
  input  logic [ADDR_W-1:0]       lookup_addr,
  output logic                    lookup_hit,
  output logic [31:0]             lookup_data,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [7:0]              awlen,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    empty
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - 5;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [DEPTH];
  logic [TAG_W-1:0]        tag_d [DEPTH];
  logic [32*LINE_WORDS-1:0] line_q [DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]       awaddr_q, awaddr_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;

  logic push_fire, retire;
  logic [PTR_W-1:0] lk_idx;
  logic unused_low_bits;

  assign unused_low_bits = ^{push_addr[4:0], lookup_addr[1:0]};

  // Capacity is judged on the registered count only, so a slot freed by a
  // retirement becomes pushable one cycle later.
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_fire  = push_valid && push_ready;
  assign retire     = (state_q == S_B) && bvalid && bready_q;

  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_fire) begin
      valid_d[wptr_q] = 1'b1;
      tag_d[wptr_q]   = push_addr[ADDR_W-1:5];
      wptr_d          = wptr_q + PTR_W'(1);
    end
    if (retire) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PTR_W'(1);
    end
    case ({push_fire, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    beat_d    = beat_q;
    case (state_q)
      S_IDLE: if (valid_q[rptr_q]) begin
        state_d   = S_AW;
        awvalid_d = 1'b1;
        awaddr_d  = {tag_q[rptr_q], 5'b0};
      end
      S_AW: if (awready) begin
        state_d   = S_W;
        awvalid_d = 1'b0;
        beat_d    = '0;
        wvalid_d  = 1'b1;
      end
      S_W: if (wready) begin
        if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
          state_d  = S_B;
          wvalid_d = 1'b0;
          bready_d = 1'b1;
          beat_d   = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_B: if (bvalid) begin
        state_d  = S_IDLE;
        bready_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers take non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  // NOTE: line data has no reset; it is only ever observed through a set valid
  // bit or while wvalid is high, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push_fire) line_q[wptr_q] <= push_data;
  end

  // Scan oldest to newest so the newest duplicate of a line wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rptr_q + PTR_W'(i);
      if (valid_q[lk_idx] && (tag_q[lk_idx] == lookup_addr[ADDR_W-1:5])) begin
        lookup_hit  = 1'b1;
        lookup_data = line_q[lk_idx][{lookup_addr[4:2], 5'b0} +: 32];
      end
    end
  end

  assign awvalid = awvalid_q;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'(LINE_WORDS - 1);
  assign wvalid  = wvalid_q;
  assign wdata   = wvalid_q ? line_q[rptr_q][{beat_q, 5'b0} +: 32] : 32'h0;
  assign wlast   = wvalid_q && (beat_q == BEAT_W'(LINE_WORDS - 1));
  assign bready  = bready_q;

endmodule

// File: tb/tb_dirty_writeback_buffer.sv
// Bench for dirty_writeback_buffer: a bus agent scoreboards every cycle against
// a queue of buffered lines while scenario tasks drive pushes and bus behaviour.
module tb_dirty_writeback_buffer;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
  } line_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         push_valid = 1'b0;
  logic         push_ready;
  logic [31:0]  push_addr = '0;
  logic [255:0] push_data = '0;
  logic [31:0]  lookup_addr = '0;
  logic         lookup_hit;
  logic [31:0]  lookup_data;
  logic         awvalid, awready = 1'b0;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         wvalid, wready = 1'b0;
  logic [31:0]  wdata;
  logic         wlast;
  logic         bvalid = 1'b0;
  logic         bready;
  logic         empty;

  dirty_writeback_buffer #(.DEPTH(DEPTH), .LINE_WORDS(8), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr), .push_data(push_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  line_t q[$];
  bit agent_en = 0, lookup_auto = 1, hold_b = 0, aw_done = 0, b_pending = 0, wtog = 0;
  int bus_mode = 0;  // 0 always ready, 1 random, 2 scripted backpressure, 3 stalled
  int beat_cnt = 0, aw_wait = 0, aw_stalls = 0, retires = 0;
  bit prev_aw_stall = 0, prev_w_stall = 0, prev_b_hs = 0;
  logic [31:0] prev_awaddr, prev_wdata, cap_awaddr;
  logic        prev_wlast;
  logic [31:0] cap_data [8];
  logic        cap_last [8];

  function automatic void model_lookup(input logic [31:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr[31:5] == a[31:5]) begin
        hit = 1'b1;
        d   = q[i].data[int'(a[4:2]) * 32 +: 32];
        break;
      end
    end
  endfunction

  always begin : agent
    logic        exp_hit;
    logic [31:0] exp_data;
    line_t       l;
    @(negedge clk);
    if (!agent_en) begin
      awready = 0; wready = 0; bvalid = 0;
      prev_aw_stall = 0; prev_w_stall = 0; prev_b_hs = 0;
    end else begin
      case (bus_mode)
        0: begin awready = 1; wready = 1; end
        1: begin awready = ($urandom_range(0, 2) != 0); wready = ($urandom_range(0, 2) != 0); end
        2: begin awready = (aw_wait >= 5); wready = !wtog; wtog = !wtog; end
        default: begin awready = 0; wready = 0; end
      endcase
      bvalid = b_pending && !hold_b && (bus_mode == 0 || bus_mode == 2 ||
               (bus_mode == 1 && $urandom_range(0, 1) == 1));
      if (lookup_auto) begin
        if (q.size() > 0 && $urandom_range(0, 2) != 0)
          lookup_addr = {q[$urandom_range(0, q.size() - 1)].addr[31:5], 5'($urandom_range(0, 31))};
        else
          lookup_addr = $urandom;
      end
      #1;
      model_lookup(lookup_addr, exp_hit, exp_data);
      n_checks++;
      if (lookup_hit !== exp_hit || lookup_data !== exp_data)
        $display("FAIL lookup addr=%h got hit=%b data=%h, want hit=%b data=%h",
                 lookup_addr, lookup_hit, lookup_data, exp_hit, exp_data);
      else n_pass++;
      n_checks++;
      if (empty !== 1'(q.size() == 0) || push_ready !== 1'(q.size() < DEPTH))
        $display("FAIL status got empty=%b push_ready=%b, want entries=%0d", empty, push_ready, q.size());
      else n_pass++;
      if (prev_aw_stall) begin
        n_checks++;
        if (awvalid !== 1'b1 || awaddr !== prev_awaddr)
          $display("FAIL aw_stable got awvalid=%b awaddr=%h, want 1 %h", awvalid, awaddr, prev_awaddr);
        else n_pass++;
      end
      if (prev_w_stall) begin
        n_checks++;
        if (wvalid !== 1'b1 || wdata !== prev_wdata || wlast !== prev_wlast)
          $display("FAIL w_stable got wvalid=%b wdata=%h wlast=%b, want 1 %h %b",
                   wvalid, wdata, wlast, prev_wdata, prev_wlast);
        else n_pass++;
      end
      if (prev_b_hs) begin
        n_checks++;
        if (awvalid !== 1'b0) $display("FAIL idle_gap got awvalid=%b right after B, want 0", awvalid);
        else n_pass++;
      end
      n_checks++;
      if ((wvalid && !aw_done) || (awvalid && (aw_done || q.size() == 0)) ||
          (bready && !b_pending) || (awvalid && awlen !== 8'd7))
        $display("FAIL protocol got awvalid=%b wvalid=%b bready=%b awlen=%0d, aw_done=%b b_pending=%b entries=%0d",
                 awvalid, wvalid, bready, awlen, aw_done, b_pending, q.size());
      else n_pass++;

      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      prev_wlast    = wlast;
      prev_b_hs     = bvalid && bready;
      if (awvalid && !awready) begin aw_wait++; aw_stalls++; end

      if (awvalid && awready && q.size() > 0) begin
        n_checks++;
        if (awaddr !== {q[0].addr[31:5], 5'b0})
          $display("FAIL awaddr got %h, want %h", awaddr, {q[0].addr[31:5], 5'b0});
        else n_pass++;
        cap_awaddr = awaddr; aw_done = 1; beat_cnt = 0; aw_wait = 0;
      end
      if (wvalid && wready) begin
        n_checks++;
        if (beat_cnt >= 8 || q.size() == 0)
          $display("FAIL extra_beat got beat %0d with %0d entries", beat_cnt, q.size());
        else if (wdata !== q[0].data[beat_cnt * 32 +: 32] || wlast !== 1'(beat_cnt == 7))
          $display("FAIL wbeat%0d got wdata=%h wlast=%b, want %h %b", beat_cnt, wdata, wlast,
                   q[0].data[beat_cnt * 32 +: 32], beat_cnt == 7);
        else n_pass++;
        if (beat_cnt < 8) begin
          cap_data[beat_cnt] = wdata;
          cap_last[beat_cnt] = wlast;
          beat_cnt++;
          if (beat_cnt == 8) b_pending = 1;
        end
      end
      if (bvalid && bready) begin
        n_checks++;
        if (beat_cnt != 8) $display("FAIL b_early got B after %0d beats, want 8", beat_cnt);
        else n_pass++;
        if (q.size() > 0) void'(q.pop_front());
        aw_done = 0; b_pending = 0; retires++;
      end
      if (push_valid && push_ready) begin
        l.addr = push_addr;
        l.data = push_data;
        q.push_back(l);
      end
    end
  end

  task automatic do_push(input logic [31:0] a, input logic [255:0] d);
    int n = 0;
    @(negedge clk);
    push_valid = 1; push_addr = a; push_data = d;
    #2;
    while (!push_ready && n < 500) begin @(negedge clk); #2; n++; end
    n_checks++;
    if (!push_ready) $display("FAIL push_timeout got push_ready=0 for addr %h, want 1", a);
    else n_pass++;
    @(negedge clk);
    push_valid = 0;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk); #2;
      if (q.size() == 0 && empty === 1'b1 && !awvalid && !wvalid && !bready) done = 1;
    end
    n_checks++;
    if (!done) $display("FAIL drain_timeout got empty=%b entries=%0d, want drained", empty, q.size());
    else n_pass++;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k * 32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if ({awvalid, wvalid, wlast, bready, push_ready, empty, lookup_hit} !== 7'b0000110)
      $display("FAIL reset_ctrl got aw/w/wl/b/pr/e/hit=%b, want 0000110",
               {awvalid, wvalid, wlast, bready, push_ready, empty, lookup_hit});
    else n_pass++;
    n_checks++;
    if (awaddr !== 32'h0 || wdata !== 32'h0 || lookup_data !== 32'h0)
      $display("FAIL reset_data got awaddr=%h wdata=%h lookup_data=%h, want 0", awaddr, wdata, lookup_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 0;
    agent_en = 1;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (awvalid !== 1'b0 || empty !== 1'b1) $display("FAIL post_reset got awvalid=%b empty=%b, want 0 1", awvalid, empty);
    else n_pass++;
  endtask

  task automatic test_single_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k * 32 +: 32] = 32'h11 * (k + 1);
    bus_mode = 0;
    do_push(32'h0000_1024, d);
    wait_drain(100);
    n_checks++;
    if (cap_awaddr !== 32'h0000_1020) $display("FAIL single_awaddr got %h, want 00001020", cap_awaddr);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (cap_data[k] !== 32'h11 * (k + 1) || cap_last[k] !== 1'(k == 7))
        $display("FAIL single_beat%0d got %h last=%b, want %h %b", k, cap_data[k], cap_last[k], 32'h11 * (k + 1), k == 7);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d = rand_line();
    bus_mode = 2; aw_stalls = 0; aw_wait = 0;
    do_push(32'h0000_6040, d);
    wait_drain(200);
    n_checks++;
    if (aw_stalls != 5 || beat_cnt != 8) $display("FAIL backpressure got aw_stalls=%0d beats=%0d, want 5 8", aw_stalls, beat_cnt);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (cap_data[k] !== d[k * 32 +: 32]) $display("FAIL bp_beat%0d got %h, want %h", k, cap_data[k], d[k * 32 +: 32]);
      else n_pass++;
    end
    bus_mode = 0;
  endtask

  task automatic test_full();
    int r0, n = 0;
    bus_mode = 3;
    do_push(32'h0000_7000, rand_line());
    do_push(32'h0000_7100, rand_line());
    @(negedge clk);
    push_valid = 1; push_addr = 32'h0000_7200; push_data = rand_line();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (push_ready !== 1'b0) $display("FAIL full_ready got push_ready=%b while full, want 0", push_ready);
      else n_pass++;
      @(negedge clk);
    end
    r0 = retires;
    bus_mode = 0;
    #2;
    while (!push_ready && n < 100) begin @(negedge clk); #2; n++; end
    n_checks++;
    if (!push_ready || retires - r0 != 1)
      $display("FAIL full_release got push_ready=%b after %0d retires, want 1 after 1", push_ready, retires - r0);
    else n_pass++;
    @(negedge clk);
    push_valid = 0;
    wait_drain(200);
    n_checks++;
    if (cap_awaddr !== 32'h0000_7200) $display("FAIL full_order got last awaddr %h, want 00007200", cap_awaddr);
    else n_pass++;
  endtask

  task automatic test_lookup();
    logic [255:0] d1 = rand_line(), d2 = rand_line();
    d1[5 * 32 +: 32] = 32'hDEAD_BEEF;
    d2[5 * 32 +: 32] = 32'hCAFE_F00D;
    bus_mode = 3; lookup_auto = 0; lookup_addr = 32'h0000_2014;
    do_push(32'h0000_2000, d1);
    #2;
    n_checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== 32'hDEAD_BEEF)
      $display("FAIL lookup_first got hit=%b data=%h, want 1 deadbeef", lookup_hit, lookup_data);
    else n_pass++;
    do_push(32'h0000_2000, d2);
    #2;
    n_checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== 32'hCAFE_F00D)
      $display("FAIL lookup_newest got hit=%b data=%h, want 1 cafef00d", lookup_hit, lookup_data);
    else n_pass++;
    bus_mode = 0;
    wait_drain(200);
    n_checks++;
    if (lookup_hit !== 1'b0 || lookup_data !== 32'h0)
      $display("FAIL lookup_retired got hit=%b data=%h, want 0 0", lookup_hit, lookup_data);
    else n_pass++;
    lookup_auto = 1;
  endtask

  task automatic test_simultaneous();
    int n = 0;
    bus_mode = 0; hold_b = 1;
    do_push(32'h0000_3000, rand_line());
    while (bready !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
    n_checks++;
    if (bready !== 1'b1) $display("FAIL simul_bready got bready=%b, want 1", bready);
    else n_pass++;
    hold_b = 0;
    @(negedge clk);
    push_valid = 1; push_addr = 32'h0000_3100; push_data = rand_line();
    #2;
    n_checks++;
    if (push_ready !== 1'b1 || bvalid !== 1'b1 || bready !== 1'b1)
      $display("FAIL simul_setup got push_ready=%b bvalid=%b bready=%b, want 111", push_ready, bvalid, bready);
    else n_pass++;
    @(negedge clk);
    push_valid = 0;
    #2;
    n_checks++;
    if (empty !== 1'b0 || push_ready !== 1'b1)
      $display("FAIL simul_count got empty=%b push_ready=%b, want 0 1", empty, push_ready);
    else n_pass++;
    wait_drain(100);
    n_checks++;
    if (cap_awaddr !== 32'h0000_3100) $display("FAIL simul_next got awaddr %h, want 00003100", cap_awaddr);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n = 0;
    bus_mode = 0;
    do_push(32'h0000_9000, rand_line());
    while (beat_cnt != 4 && n < 50) begin @(negedge clk); #2; n++; end
    n_checks++;
    if (wvalid !== 1'b1 || beat_cnt != 4) $display("FAIL arst_setup got wvalid=%b beats=%0d, want 1 4", wvalid, beat_cnt);
    else n_pass++;
    agent_en = 0;
    #1 reset = 1;
    #1;
    n_checks++;
    if ({wvalid, awvalid, bready, wlast, empty, push_ready} !== 6'b000011)
      $display("FAIL arst_async got w/aw/b/wl/e/pr=%b, want 000011", {wvalid, awvalid, bready, wlast, empty, push_ready});
    else n_pass++;
    q.delete();
    aw_done = 0; b_pending = 0; beat_cnt = 0;
    @(negedge clk);
    reset = 0;
    agent_en = 1;
    repeat (10) @(negedge clk);
    #2;
    n_checks++;
    if (awvalid !== 1'b0 || empty !== 1'b1) $display("FAIL arst_quiet got awvalid=%b empty=%b, want 0 1", awvalid, empty);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] bases [4];
    bases[0] = 32'h0000_4000; bases[1] = 32'h0000_4020;
    bases[2] = 32'h0000_8000; bases[3] = 32'h0001_A0E0;
    bus_mode = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_push(bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 31)), rand_line());
    end
    wait_drain(3000);
    bus_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_full();
    test_lookup();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dirty_writeback_buffer.md
Name: dirty_writeback_buffer

Overview:
Write-back buffer between the data cache and the memory bus. When the cache evicts a line whose dirty bit is set, it pushes the whole line here and continues without waiting. The buffer drains lines to memory as single-ID 8-beat write bursts using an AXI-style AW/W/B handshake. It also serves read lookups, so a line sitting in the buffer is never re-fetched stale from memory.

Parameters:
DEPTH, 2, number of line entries (power of two, >=2)
LINE_WORDS, 8, 32-bit words per line (fixed 8; awlen = LINE_WORDS-1)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
push_valid  in  1  cache offers an evicted dirty line
push_ready  out  1  buffer accepts line (not full)
push_addr  in  ADDR_W  line base address, bits [4:0] ignored (treated as 0)
push_data  in  32*LINE_WORDS  line data, word k at bits [32k+31:32k]
lookup_addr  in  ADDR_W  read-miss address from cache
lookup_hit  out  1  lookup_addr line present in buffer
lookup_data  out  32  word lookup_addr[4:2] of the hit line
awvalid  out  1  write address valid
awready  in  1  write address ready
awaddr  out  ADDR_W  burst base address (line aligned)
awlen  out  8  burst length-1, constant 7
wvalid  out  1  write data valid
wready  in  1  write data ready
wdata  out  32  write data beat
wlast  out  1  final beat of burst
bvalid  in  1  write response valid
bready  out  1  write response ready
empty  out  1  no valid entries

Behaviour:
- Interface: one clock domain on clk. reset is asynchronous and active-high; it clears all state immediately, without waiting for a clk edge.
- Reset values: all entries invalid, write/read pointers 0, FSM IDLE, beat counter 0. Outputs after reset: push_ready=1, empty=1, awvalid=0, wvalid=0, wlast=0, bready=0, lookup_hit=0, lookup_data=0, awaddr=0, wdata=0.
- Storage: circular FIFO of DEPTH entries, each holding a valid bit, line address [ADDR_W-1:5] and LINE_WORDS data words.
- Push:
  - Accepted when push_valid & push_ready at a rising clk edge.
  - The entry is written at wptr; wptr then increments modulo DEPTH.
  - push_ready = !full, taken from registered count only. A retirement in the same cycle does not free the slot until the next cycle.
- Drain FSM, serving the head entry at rptr:
  - IDLE: if the head entry is valid, go to AW. awaddr <= head address with low 5 bits zero; awvalid <= 1.
  - AW: hold awvalid, awaddr and awlen stable until awready. On awvalid&awready go to W: awvalid <= 0, beat <= 0, wvalid <= 1.
  - W: wdata = head word[beat], wlast = (beat==7). On each wvalid&wready, beat increments. wdata and wlast are stable while wready is low. On the beat-7 handshake, wvalid <= 0 and bready <= 1, then go to B.
  - B: on bvalid&bready, head entry valid <= 0, rptr increments modulo DEPTH, bready <= 0, return to IDLE. The bresp value is ignored.
  - Minimum cost per line: 1 AW + 8 W + 1 B handshake cycles, plus 1 IDLE cycle. There are no back-to-back bursts without an IDLE cycle.
  - AW and W are strictly sequential; wvalid is never asserted before the AW handshake.
- Lookup (combinational):
  - An entry matches if it is valid and its address equals lookup_addr[ADDR_W-1:5].
  - lookup_hit = any match. lookup_data = word lookup_addr[4:2] of the newest matching entry (closest to wptr); 0 when there is no hit.
  - The entry currently draining stays hittable until its B handshake completes.
  - A line pushed at edge N is visible to lookup from the cycle after edge N.
- Duplicates: the same line may be pushed twice. Both entries drain in order, and lookup returns the newer one.
- Count/empty:
  - count is 0..DEPTH. It increments on push only, decrements on retire only, and is unchanged on simultaneous push and retire.
  - empty = (count==0). full = (count==DEPTH).
- Reset mid-burst: the burst is abandoned and buffered lines are lost. awvalid, wvalid and bready drop to 0 asynchronously. The bus agent must tolerate the truncated burst.

Test Plan:
- Single line: after reset, push addr 0x0000_1024, data words 0x11..0x88 -> awaddr=0x0000_1020, awlen=7; 8 beats wdata 0x11..0x88 with wlast only on beat 8; bready after the last beat; empty=1 after bvalid.
- Backpressure: wready toggles 1-0-1-0 and awready is held low 5 cycles -> awaddr, wdata and wlast stay stable while not ready; exactly 8 beats are transferred; word order is preserved.
- Full: push 2 lines with awready=0 -> push_ready=0; a 3rd push_valid is held off. Complete the first burst's B -> push_ready=1 the next cycle; the 3rd line drains after the 2nd, in FIFO order.
- Lookup forwarding: push line 0x2000 (word 5 = 0xDEAD_BEEF) and stall the bus; lookup 0x2014 -> hit=1, data=0xDEAD_BEEF. Push 0x2000 again with word 5 = 0xCAFE_F00D -> data=0xCAFE_F00D. After both B handshakes -> hit=0.
- Simultaneous push and retire while count=1: count stays 1, wptr/rptr both advance, empty=0, and the new line drains next.
- Async reset during W beat 4: assert reset mid-cycle -> wvalid=0 and empty=1 immediately, before the next clk edge; push_ready=1; no further AW until a new push.
